// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the baud generator, control block and shift register.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spi_shift_state_t;

  localparam int SPI_DEFAULT_DATA_WIDTH = 8;

  // Maps a transfer-order position onto the tx word bit position.
  function automatic logic [4:0] spi_bit_idx(input logic [4:0] count,
                                             input logic       lsbfe,
                                             input logic [4:0] width);
    return lsbfe ? count : (width - 5'd1 - count);
  endfunction

endpackage

// File: rtl/spi_shift_register.sv
// SPI master data path: serialises the TX word onto mosi_o and assembles the
// RX word from miso_i, paced by the baud generator's send/sample strobes.
module spi_shift_register
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DEFAULT_DATA_WIDTH
) (
  input  logic                  PCLK,
  input  logic                  PRESET_n,
  input  logic                  ss_i,
  input  logic                  send_data_i,
  input  logic [DATA_WIDTH-1:0] data_mosi_i,
  input  logic                  lsbfe_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  mosi_send_sclk_i,
  input  logic                  mosi_send_sclk0_i,
  input  logic                  miso_receive_sclk_i,
  input  logic                  miso_receive_sclk0_i,
  input  logic                  miso_i,
  output logic                  mosi_o,
  output logic [DATA_WIDTH-1:0] data_miso_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  abort_o
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam int IW = $clog2(DATA_WIDTH);

  // state | meaning
  // IDLE  | waiting for a load strobe
  // ARMED | word loaded, waiting for ss_i low
  // SHIFT | moving bits on the selected strobes
  // DONE  | one-cycle completion, rx_valid_o high
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ARMED = ARMED;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_data_miso;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_sidx;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_lsbfe;
  logic                  r_mosi;
  logic                  r_rx_valid;
  logic                  r_abort;

  logic                  w_send;
  logic                  w_recv;
  logic                  w_last;
  logic [IW-1:0]         w_send_pos;
  logic [DATA_WIDTH-1:0] w_rx_next;

  // Strobe pair chosen from the configuration latched at load time.
  assign w_send = (r_cpol == r_cpha) ? mosi_send_sclk_i    : mosi_send_sclk0_i;
  assign w_recv = (r_cpol == r_cpha) ? miso_receive_sclk_i : miso_receive_sclk0_i;

  assign w_send_pos = IW'(spi_bit_idx(5'(r_sidx), r_lsbfe, 5'(DATA_WIDTH)));
  assign w_rx_next  = r_lsbfe ? {miso_i, r_rx[DATA_WIDTH-1:1]}
                              : {r_rx[DATA_WIDTH-2:0], miso_i};
  assign w_last     = (r_cnt == CW'(DATA_WIDTH - 1));

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      r_state     <= ST_IDLE;
      r_tx        <= '0;
      r_rx        <= '0;
      r_data_miso <= '0;
      r_cnt       <= '0;
      r_sidx      <= '0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_lsbfe     <= 1'b0;
      r_mosi      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_abort    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (send_data_i) begin
            r_tx    <= data_mosi_i;
            r_cpol  <= cpol_i;
            r_cpha  <= cpha_i;
            r_lsbfe <= lsbfe_i;
            r_rx    <= '0;
            r_cnt   <= '0;
            r_sidx  <= '0;
            r_state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!ss_i) begin
            r_state <= ST_SHIFT;
            if (!r_cpha) begin
              r_mosi <= r_tx[w_send_pos];
              r_sidx <= CW'(1);
            end else begin
              r_sidx <= '0;
            end
          end
        end
        ST_SHIFT: begin
          if (ss_i) begin
            r_state <= ST_IDLE;
            r_mosi  <= 1'b0;
            r_abort <= 1'b1;
            r_rx    <= '0;
            r_cnt   <= '0;
            r_sidx  <= '0;
          end else begin
            if (w_send && (r_sidx < CW'(DATA_WIDTH))) begin
              r_mosi <= r_tx[w_send_pos];
              r_sidx <= r_sidx + CW'(1);
            end
            if (w_recv) begin
              r_rx  <= w_rx_next;
              r_cnt <= r_cnt + CW'(1);
              // Word is published on DONE entry so rx_valid_o and data_miso_o
              // change together, one PCLK after the final sample strobe.
              if (w_last) begin
                r_state     <= ST_DONE;
                r_data_miso <= w_rx_next;
                r_rx_valid  <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_mosi  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mosi_o      = r_mosi;
  assign data_miso_o = r_data_miso;
  assign rx_valid_o  = r_rx_valid;
  assign abort_o     = r_abort;
  assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_shift_register.sv
// Randomised bench for spi_shift_register: a queue-based frame model is
// compared against the DUT outputs every cycle, plus literal frame checks.
module tb_spi_shift_register;

  localparam int W = 8;

  logic         PCLK;
  logic         PRESET_n;
  logic         ss_i;
  logic         send_data_i;
  logic [W-1:0] data_mosi_i;
  logic         lsbfe_i;
  logic         cpol_i;
  logic         cpha_i;
  logic         mosi_send_sclk_i;
  logic         mosi_send_sclk0_i;
  logic         miso_receive_sclk_i;
  logic         miso_receive_sclk0_i;
  logic         miso_i;
  logic         mosi_o;
  logic [W-1:0] data_miso_o;
  logic         rx_valid_o;
  logic         busy_o;
  logic         abort_o;

  spi_shift_register #(.DATA_WIDTH(W)) dut (
    .PCLK                 (PCLK),
    .PRESET_n             (PRESET_n),
    .ss_i                 (ss_i),
    .send_data_i          (send_data_i),
    .data_mosi_i          (data_mosi_i),
    .lsbfe_i              (lsbfe_i),
    .cpol_i               (cpol_i),
    .cpha_i               (cpha_i),
    .mosi_send_sclk_i     (mosi_send_sclk_i),
    .mosi_send_sclk0_i    (mosi_send_sclk0_i),
    .miso_receive_sclk_i  (miso_receive_sclk_i),
    .miso_receive_sclk0_i (miso_receive_sclk0_i),
    .miso_i               (miso_i),
    .mosi_o               (mosi_o),
    .data_miso_o          (data_miso_o),
    .rx_valid_o           (rx_valid_o),
    .busy_o               (busy_o),
    .abort_o              (abort_o)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a queue of bits to send and a queue of
  // bits received; the RX word is assembled only when the frame completes.
  int           m_phase = 0;   // 0 idle, 1 waiting for ss, 2 transferring, 3 complete
  bit           q_tx[$];
  bit           q_rx[$];
  logic         m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;
  logic         m_mosi = 1'b0;
  logic [W-1:0] m_word = '0;
  logic         m_valid = 1'b0, m_abort = 1'b0;
  logic         m_s, m_r;

  initial forever begin
    @(posedge PCLK or negedge PRESET_n);
    if (!PRESET_n) begin
      m_phase = 0;
      q_tx.delete();
      q_rx.delete();
      m_mosi = 1'b0; m_word = '0; m_valid = 1'b0; m_abort = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_abort = 1'b0;
      case (m_phase)
        0: if (send_data_i) begin
          q_tx.delete();
          q_rx.delete();
          for (int i = 0; i < W; i++)
            q_tx.push_back(lsbfe_i ? data_mosi_i[i] : data_mosi_i[W-1-i]);
          m_cpol = cpol_i; m_cpha = cpha_i; m_lsb = lsbfe_i;
          m_phase = 1;
        end
        1: if (!ss_i) begin
          m_phase = 2;
          if (!m_cpha) m_mosi = q_tx.pop_front();
        end
        2: if (ss_i) begin
          m_phase = 0; m_mosi = 1'b0; m_abort = 1'b1;
          q_rx.delete();
        end else begin
          m_s = (m_cpol == m_cpha) ? mosi_send_sclk_i    : mosi_send_sclk0_i;
          m_r = (m_cpol == m_cpha) ? miso_receive_sclk_i : miso_receive_sclk0_i;
          if (m_s && q_tx.size() != 0) m_mosi = q_tx.pop_front();
          if (m_r) begin
            q_rx.push_back(miso_i);
            if (q_rx.size() == W) begin
              for (int i = 0; i < W; i++) m_word[m_lsb ? i : W-1-i] = q_rx[i];
              m_valid = 1'b1;
              m_phase = 3;
            end
          end
        end
        default: begin m_phase = 0; m_mosi = 1'b0; end
      endcase
    end
  end

  initial forever begin
    @(negedge PCLK);
    if (chk_en) begin
      check("mosi_o",      16'(mosi_o),      16'(m_mosi));
      check("busy_o",      16'(busy_o),      16'(m_phase != 0));
      check("rx_valid_o",  16'(rx_valid_o),  16'(m_valid));
      check("abort_o",     16'(abort_o),     16'(m_abort));
      check("data_miso_o", 16'(data_miso_o), 16'(m_word));
    end
  end

  task automatic clear_strobes();
    mosi_send_sclk_i = 1'b0; mosi_send_sclk0_i = 1'b0;
    miso_receive_sclk_i = 1'b0; miso_receive_sclk0_i = 1'b0;
    send_data_i = 1'b0;
  endtask

  // Noise that must not disturb a frame: unselected strobes, loads, config toggles.
  task automatic spurious(input logic sel);
    if (sel) begin
      mosi_send_sclk0_i = 1'($urandom); miso_receive_sclk0_i = 1'($urandom);
    end else begin
      mosi_send_sclk_i = 1'($urandom); miso_receive_sclk_i = 1'($urandom);
    end
    send_data_i = 1'($urandom);
    data_mosi_i = 8'hFF;
    lsbfe_i = 1'($urandom); cpol_i = 1'($urandom); cpha_i = 1'($urandom);
  endtask

  task automatic strobe(input logic s, input logic r, input logic m,
                        input logic sel, input logic spur);
    repeat ($urandom_range(0, 2)) begin
      miso_i = 1'($urandom);
      if (spur) spurious(sel);
      @(negedge PCLK);
      clear_strobes();
    end
    miso_i = m;
    if (sel) begin mosi_send_sclk_i = s; miso_receive_sclk_i = r; end
    else     begin mosi_send_sclk0_i = s; miso_receive_sclk0_i = r; end
    if (spur) spurious(sel);
    @(negedge PCLK);
    clear_strobes();
  endtask

  task automatic run_frame(input logic [W-1:0] tx, input logic [W-1:0] rxw,
                           input logic cpol, input logic cpha, input logic lsb,
                           input int abort_after, input int reset_after,
                           input logic spur, input logic [W-1:0] exp_seq);
    logic         sel;
    logic [W-1:0] seq;
    logic         split;
    sel = (cpol == cpha);
    seq = '0;
    data_mosi_i = tx; cpol_i = cpol; cpha_i = cpha; lsbfe_i = lsb;
    send_data_i = 1'b1;
    @(negedge PCLK);
    send_data_i = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge PCLK);
    ss_i = 1'b0;
    @(negedge PCLK);
    if (!cpha) seq = {seq[W-2:0], mosi_o};
    else begin
      check("first_bit_wait", 16'(mosi_o), 16'(0));
      strobe(1'b1, 1'b0, 1'b0, sel, spur);
      seq = {seq[W-2:0], mosi_o};
    end
    for (int b = 0; b < W; b++) begin
      if (b == abort_after) begin
        ss_i = 1'b1;
        @(negedge PCLK);
        return;
      end
      if (b == reset_after) begin
        #2 PRESET_n = 1'b0;
        #1;
        return;
      end
      split = 1'($urandom);
      if (split) begin
        strobe(1'b0, 1'b1, lsb ? rxw[b] : rxw[W-1-b], sel, spur);
        if (b < W-1) begin
          strobe(1'b1, 1'b0, 1'b0, sel, spur);
          seq = {seq[W-2:0], mosi_o};
        end
      end else begin
        // On the last bit the send strobe is surplus and must be ignored.
        strobe(1'b1, 1'b1, lsb ? rxw[b] : rxw[W-1-b], sel, spur);
        if (b < W-1) seq = {seq[W-2:0], mosi_o};
      end
    end
    check("rx_valid_at_done", 16'(rx_valid_o), 16'(1));
    check("rx_word",          16'(data_miso_o), 16'(rxw));
    check("mosi_sequence",    16'(seq),         16'(exp_seq));
    ss_i = 1'($urandom);
    @(negedge PCLK);
    check("idle_after_done", 16'(busy_o), 16'(0));
  endtask

  logic [W-1:0] r_tx, r_rx, r_seq;
  logic         r_cp, r_ch, r_lb, r_sp;

  initial begin
    PRESET_n = 1'b0; ss_i = 1'b1; miso_i = 1'b0;
    data_mosi_i = '0; lsbfe_i = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0;
    clear_strobes();
    repeat (2) @(negedge PCLK);
    PRESET_n = 1'b1;
    chk_en = 1'b1;
    check("reset_mosi",  16'(mosi_o),      16'(0));
    check("reset_busy",  16'(busy_o),      16'(0));
    check("reset_rx",    16'(data_miso_o), 16'(0));
    check("reset_valid", 16'(rx_valid_o),  16'(0));
    check("reset_abort", 16'(abort_o),     16'(0));

    // Mode 0, MSB first.
    run_frame(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0, 8'hA5);

    // Abort after three samples.
    run_frame(8'h55, 8'hFF, 1'b0, 1'b0, 1'b0, 3, -1, 1'b0, 8'h00);
    check("abort_pulse",     16'(abort_o),     16'(1));
    check("abort_busy",      16'(busy_o),      16'(0));
    check("abort_mosi",      16'(mosi_o),      16'(0));
    check("abort_rx_kept",   16'(data_miso_o), 16'(8'h3C));
    check("abort_no_valid",  16'(rx_valid_o),  16'(0));
    @(negedge PCLK);
    check("abort_one_cycle", 16'(abort_o),     16'(0));

    // Mode 3, LSB first.
    run_frame(8'h81, 8'h96, 1'b1, 1'b1, 1'b1, -1, -1, 1'b0, 8'h81);
    // Modes 1 and 2 with noise on the unused strobe pair.
    run_frame(8'h3C, 8'h5A, 1'b0, 1'b1, 1'b0, -1, -1, 1'b1, 8'h3C);
    run_frame(8'hC5, 8'h5A, 1'b1, 1'b0, 1'b1, -1, -1, 1'b1, 8'hA3);
    // Mode 0 with mid-frame loads of 8'hFF and lsbfe toggling.
    run_frame(8'h6B, 8'hE1, 1'b0, 1'b0, 1'b0, -1, -1, 1'b1, 8'h6B);

    // Asynchronous reset after four bits.
    run_frame(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, -1, 4, 1'b0, 8'h00);
    check("rst_mosi",  16'(mosi_o),      16'(0));
    check("rst_busy",  16'(busy_o),      16'(0));
    check("rst_rx",    16'(data_miso_o), 16'(0));
    check("rst_valid", 16'(rx_valid_o),  16'(0));
    check("rst_abort", 16'(abort_o),     16'(0));
    @(negedge PCLK);
    PRESET_n = 1'b1;
    ss_i = 1'b1;
    @(negedge PCLK);
    run_frame(8'hC3, 8'hC3, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0, 8'hC3);

    for (int k = 0; k < 30; k++) begin
      r_tx = W'($urandom); r_rx = W'($urandom);
      r_cp = 1'($urandom); r_ch = 1'($urandom);
      r_lb = 1'($urandom); r_sp = 1'($urandom);
      for (int i = 0; i < W; i++) r_seq[W-1-i] = r_lb ? r_tx[i] : r_tx[W-1-i];
      run_frame(r_tx, r_rx, r_cp, r_ch, r_lb, -1, -1, r_sp, r_seq);
    end

    ss_i = 1'b1;
    repeat (3) @(negedge PCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
